// File: rtl/conv_datapath_n.sv
// conv_datapath_n: masked multi-lane MAC (P1 products, P2 accumulate, P3 scale/ReLU/saturate).
// Optional 1x2 max pooling on the output is built only when CONV_DP_MAXPOOL_EN is defined.

module conv_lane_mul #(
   parameter int DWIDTH = 8
) (
   input  logic [DWIDTH-1:0]   img_i,
   input  logic [DWIDTH-1:0]   kern_i,
   input  logic                en_i,
   output logic [2*DWIDTH-1:0] prod_o
);
   logic signed [2*DWIDTH-1:0] img_x, kern_x;

   assign img_x  = {{DWIDTH{img_i[DWIDTH-1]}}, img_i};
   assign kern_x = {{DWIDTH{kern_i[DWIDTH-1]}}, kern_i};
   assign prod_o = en_i ? img_x * kern_x : '0;
endmodule

module conv_datapath_n #(
   parameter int LANES         = 3,
   parameter int DWIDTH        = 8,
   parameter int ACC_WIDTH     = 20,
   parameter int RESULT_DWIDTH = 8,
   parameter int SHFT_WIDTH    = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [SHFT_WIDTH-1:0]     cfg_shift,
   input  logic [LANES-1:0]          cfg_mask,
   input  logic                      cfg_relu,
   input  logic                      cfg_pool_en,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_last,
   input  logic                      in_row_end,
   input  logic [LANES*DWIDTH-1:0]   img_data,
   input  logic [LANES*DWIDTH-1:0]   kern_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [RESULT_DWIDTH-1:0]  out_data,
   output logic                      accum_ovrflow,
   input  logic                      clr_ovrflow
);
   localparam int PW = 2*DWIDTH;
   // Sum width holds any accumulator plus one beat of lane products without loss.
   localparam int SW = ((ACC_WIDTH > PW + 3) ? ACC_WIDTH : PW + 3) + 1;
   localparam int RW = ACC_WIDTH + 2;
   localparam logic signed [RW-1:0] RMAX = RW'((1 << (RESULT_DWIDTH-1)) - 1);
   localparam logic signed [RW-1:0] RMIN = ~RMAX;

   logic                            adv, fire;
   logic [LANES-1:0][PW-1:0]        prod_c, prod_q;
   logic [2:1]                      vld_pipe_q, last_pipe_q, row_pipe_q;
   logic signed [SW-1:0]            lsum, nacc;
   logic signed [ACC_WIDTH-1:0]     acc_q, acc_d;
   logic                            first_q, ovf_c, ovf_q;
   logic signed [RW-1:0]            ext, rsum, sh;
   logic [RW-1:0]                   rnd;
   logic signed [RESULT_DWIDTH-1:0] res_c;
   logic                            out_vld_q, out_vld_d;
   logic signed [RESULT_DWIDTH-1:0] out_dat_q, out_dat_d;

   assign adv      = ~out_vld_q | out_ready;
   assign fire     = adv & vld_pipe_q[2] & last_pipe_q[2];
   assign in_ready = adv;

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      conv_lane_mul #(.DWIDTH(DWIDTH)) u_lane (
         .img_i  (img_data[gi*DWIDTH +: DWIDTH]),
         .kern_i (kern_data[gi*DWIDTH +: DWIDTH]),
         .en_i   (cfg_mask[gi]),
         .prod_o (prod_c[gi])
      );
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_pipe_q  <= '0;
         last_pipe_q <= '0;
         row_pipe_q  <= '0;
         prod_q      <= '0;
      end else if (adv) begin
         vld_pipe_q  <= {vld_pipe_q[1], in_valid};
         last_pipe_q <= {last_pipe_q[1], in_valid & in_last};
         row_pipe_q  <= {row_pipe_q[1], in_valid & in_last & in_row_end};
         if (in_valid) prod_q <= prod_c;
      end
   end

   always_comb begin
      lsum = '0;
      for (int i = 0; i < LANES; i++) lsum = lsum + SW'($signed(prod_q[i]));
      nacc  = (first_q ? '0 : SW'(acc_q)) + lsum;
      acc_d = nacc[ACC_WIDTH-1:0];
      ovf_c = vld_pipe_q[1] && (nacc != SW'(acc_d));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q   <= '0;
         first_q <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         // A fresh overflow wins over a simultaneous clear.
         ovf_q <= (ovf_q & ~clr_ovrflow) | (adv & ovf_c);
         if (adv && vld_pipe_q[1]) begin
            acc_q   <= acc_d;
            first_q <= last_pipe_q[1];
         end
      end
   end

   // Round half up: add 2^(shift-1) (zero when shift is 0), then arithmetic shift.
   always_comb begin
      ext  = RW'(acc_q);
      rnd  = (RW'(1) << cfg_shift) >> 1;
      rsum = ext + $signed(rnd);
      sh   = rsum >>> cfg_shift;
      if (cfg_relu && sh < 0) sh = '0;
      if (sh > RMAX)      res_c = RMAX[RESULT_DWIDTH-1:0];
      else if (sh < RMIN) res_c = RMIN[RESULT_DWIDTH-1:0];
      else                res_c = sh[RESULT_DWIDTH-1:0];
   end

`ifdef CONV_DP_MAXPOOL_EN
   logic                            pend_vld_q, pend_vld_d;
   logic signed [RESULT_DWIDTH-1:0] pend_dat_q, pend_dat_d;

   always_comb begin
      out_vld_d  = out_vld_q & ~out_ready;
      out_dat_d  = out_dat_q;
      pend_vld_d = pend_vld_q;
      pend_dat_d = pend_dat_q;
      if (fire) begin
         if (!cfg_pool_en) begin
            out_vld_d = 1'b1;
            out_dat_d = res_c;
         end else if (pend_vld_q) begin
            out_vld_d  = 1'b1;
            out_dat_d  = (res_c > pend_dat_q) ? res_c : pend_dat_q;
            pend_vld_d = 1'b0;
         end else if (row_pipe_q[2]) begin
            // Odd result at the end of a row goes out alone.
            out_vld_d = 1'b1;
            out_dat_d = res_c;
         end else begin
            pend_vld_d = 1'b1;
            pend_dat_d = res_c;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_vld_q <= 1'b0;
         pend_dat_q <= '0;
      end else begin
         pend_vld_q <= pend_vld_d;
         pend_dat_q <= pend_dat_d;
      end
   end
`else
   logic pool_unused;
   assign pool_unused = cfg_pool_en ^ row_pipe_q[2];

   always_comb begin
      out_vld_d = out_vld_q & ~out_ready;
      out_dat_d = out_dat_q;
      if (fire) begin
         out_vld_d = 1'b1;
         out_dat_d = res_c;
      end
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_vld_q <= 1'b0;
         out_dat_q <= '0;
      end else begin
         out_vld_q <= out_vld_d;
         out_dat_q <= out_dat_d;
      end
   end

   assign out_valid     = out_vld_q;
   assign out_data      = out_dat_q;
   assign accum_ovrflow = ovf_q;
endmodule

// File: doc/conv_datapath_n.md
CONV_DATAPATH_N -- requirements
Module: conv_datapath_n

Interface
REQ-001 Parameter LANES, 3, parallel multiply lanes (1..8).
REQ-002 Parameter DWIDTH, 8, signed width of each image/kernel element.
REQ-003 Parameter ACC_WIDTH, 20, signed accumulator width.
REQ-004 Parameter RESULT_DWIDTH, 8, signed output width.
REQ-005 Parameter SHFT_WIDTH, 4, width of cfg_shift.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 cfg_shift  in  SHFT_WIDTH  arithmetic right-shift applied to window sum.
REQ-009 cfg_mask  in  LANES  per-lane enable; 0 forces lane product to zero.
REQ-010 cfg_relu  in  1  1 clamps negative results to 0.
REQ-011 cfg_pool_en  in  1  1 enables 1x2 max pooling of consecutive window results.
REQ-012 in_valid / in_ready  in / out  1 / 1  input beat handshake; beat accepted when both high.
REQ-013 in_last  in  1  accepted beat is last of current kernel window.
REQ-014 in_row_end  in  1  qualified by in_last; closes current pooling row.
REQ-015 img_data, kern_data  in  LANES*DWIDTH  lane i at bits [i*DWIDTH +: DWIDTH], two's complement.
REQ-016 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-017 out_data  out  RESULT_DWIDTH  signed result.
REQ-018 accum_ovrflow  out  1  sticky accumulator overflow flag.
REQ-019 clr_ovrflow  in  1  synchronous clear of accum_ovrflow.

Function
REQ-020 Stage P1 SHALL register masked full-precision signed products (2*DWIDTH each) of accepted beats, with beat valid, last, row_end tags.
REQ-021 Stage P2 SHALL sign-extend and sum all lane products and add to accumulator; accumulator starts from 0 on first beat after a last beat or reset.
REQ-022 If an accumulation result falls outside signed ACC_WIDTH range, the accumulator SHALL wrap modulo 2^ACC_WIDTH and accum_ovrflow SHALL set.
REQ-023 clr_ovrflow and a new overflow in the same cycle: flag SHALL remain 1.
REQ-024 Stage P3, on a last-tagged sum: arithmetic right shift by cfg_shift, round half up (add 2^(cfg_shift-1) before shift when cfg_shift>0), then ReLU if cfg_relu, then saturate to signed RESULT_DWIDTH.
REQ-025 Pool disabled: every P3 result SHALL load the output register.
REQ-026 Pool enabled: first result of a pair held in a pending register; second emits max(pending, new), pending cleared.
REQ-027 Window with in_row_end and pool pending after it: pending value SHALL be emitted alone (flush); no pairing across rows.
REQ-028 Latency: in_last beat accepted at cycle t -> out_valid high at t+3 (no pool or pair-completing result, no stall).
REQ-029 out_valid SHALL hold, out_data stable, until out_ready high; then deassert unless a new result loads the same cycle.
REQ-030 Global advance enable = !out_valid | out_ready; in_ready SHALL equal it; P1-P3 and pool SHALL freeze while low.
REQ-031 cfg_* SHALL be sampled per stage; changes only permitted between windows.

Reset
REQ-032 reset_n low: out_valid=0, out_data=0, in_ready=1 after release, accum_ovrflow=0, accumulator, pipeline tags, and pool pending cleared.
REQ-033 Reset mid-window SHALL discard the partial window; no result emitted for it.

Configuration
REQ-034 Macro CONV_DP_MAXPOOL_EN defined: pool logic per REQ-026/027 present.
REQ-035 Macro undefined: no pool hardware; cfg_pool_en and in_row_end ignored; behaviour per REQ-025.

Verification
REQ-036 LANES=3, mask=111, shift=0, one beat img=(1,2,3) kern=(4,5,6) last -> out_data=32 at t+3.
REQ-037 Three beats img=(-128 each), kern=(127 each), shift=4 -> sum=-146304, ACC_WIDTH=20 no overflow; out_data=-128 (saturated).
REQ-038 shift=2, sum=6 -> out 2 (6+2>>2); sum=-6 -> out -1; cfg_relu=1, sum=-6 -> 0.
REQ-039 Pool enabled, window results 5, 9, 3 with row_end on third -> outputs 9 then 3; no output after first.
REQ-040 out_ready held low 10 cycles with out_valid high -> in_ready low, out_data unchanged, no beat lost; release -> remaining results in order.
REQ-041 Accumulate beyond 2^19-1 -> accum_ovrflow=1, stays 1 until clr_ovrflow; reset_n pulse mid-window -> next window result unaffected.
